// File: rtl/ooo_decode_issue_queue.sv
// In-order decode->execute issue FIFO. The head packet issues only when its target
// functional unit is not stalled; supports flush, sticky halt and occupancy reporting.
module ooo_decode_issue_queue #(
    parameter int DEPTH     = 4,
    parameter int PAYLOAD_W = 256,
    parameter int NUM_FU    = 5,
    parameter int FU_W      = $clog2(NUM_FU),
    parameter int CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_flush,
    input  logic                 i_enq_valid,
    output logic                 o_enq_ready,
    input  logic [PAYLOAD_W-1:0] i_enq_payload,
    input  logic [FU_W-1:0]      i_enq_fu,
    input  logic                 i_enq_halt,
    input  logic [NUM_FU-1:0]    i_fu_stall,
    output logic                 o_issue_valid,
    output logic [PAYLOAD_W-1:0] o_issue_payload,
    output logic [FU_W-1:0]      o_issue_fu,
    output logic                 o_issue_halt,
    output logic [CNT_W-1:0]     o_count,
    output logic                 o_empty,
    output logic                 o_full,
    output logic                 o_halted
);

    localparam int PTR_W = $clog2(DEPTH);

    typedef struct packed {
        logic [PAYLOAD_W-1:0] payload;
        logic [FU_W-1:0]      fu;
        logic                 halt;
    } entry_t;

    entry_t           r_mem [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_halted;

    entry_t w_head;
    entry_t w_enq_entry;
    logic   w_empty;
    logic   w_full;
    logic   w_enq_ready;
    logic   w_enq_fire;
    logic   w_head_stall;
    logic   w_issue;

    function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_head      = r_mem[r_rd_ptr];
    assign w_enq_entry = '{payload: i_enq_payload, fu: i_enq_fu, halt: i_enq_halt};
    assign w_empty     = (r_count == '0);
    assign w_full      = (r_count == CNT_W'(DEPTH));
    assign w_enq_ready = !w_full && !r_halted;
    assign w_enq_fire  = i_enq_valid && w_enq_ready;

    // An out-of-range FU index matches no stall bit and therefore stays blocked.
    always_comb begin
        w_head_stall = 1'b1;
        for (int i = 0; i < NUM_FU; i++) begin
            if (w_head.fu == FU_W'(i)) w_head_stall = i_fu_stall[i];
        end
    end

    assign w_issue = !w_empty && !w_head_stall && !i_flush;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_halted <= 1'b0;
        end else if (i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_halted <= 1'b0;
        end else begin
            if (w_enq_fire) begin
                r_wr_ptr <= bump(r_wr_ptr);
                if (i_enq_halt) r_halted <= 1'b1;
            end
            if (w_issue) r_rd_ptr <= bump(r_rd_ptr);
            case ({w_enq_fire, w_issue})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge i_clk) begin
        if (w_enq_fire && !i_flush) r_mem[r_wr_ptr] <= w_enq_entry;
    end

    assign o_enq_ready     = w_enq_ready;
    assign o_issue_valid   = w_issue;
    assign o_issue_payload = w_issue ? w_head.payload : '0;
    assign o_issue_fu      = w_issue ? w_head.fu : '0;
    assign o_issue_halt    = w_issue && w_head.halt;
    assign o_count         = r_count;
    assign o_empty         = w_empty;
    assign o_full          = w_full;
    assign o_halted        = r_halted;

    a_count_le_depth: assert property (@(posedge i_clk) disable iff (i_rst)
        r_count <= CNT_W'(DEPTH));
    a_empty_match: assert property (@(posedge i_clk) disable iff (i_rst)
        w_empty == (r_count == '0));
    a_full_match: assert property (@(posedge i_clk) disable iff (i_rst)
        w_full == (r_count == CNT_W'(DEPTH)));
    a_head_fu_legal: assert property (@(posedge i_clk) disable iff (i_rst)
        !w_empty |-> (int'(w_head.fu) < NUM_FU));

endmodule

// File: tb/tb_ooo_decode_issue_queue.sv
// Directed bench for ooo_decode_issue_queue: a table of per-cycle vectors plus
// hand-written sequences for steady-state wrap and mid-operation reset.
module tb_ooo_decode_issue_queue;

    localparam int DEPTH     = 4;
    localparam int PAYLOAD_W = 256;
    localparam int NUM_FU    = 5;
    localparam int FU_W      = $clog2(NUM_FU);
    localparam int CNT_W     = $clog2(DEPTH + 1);

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 flush;
    logic                 enq_valid;
    logic                 enq_ready;
    logic [PAYLOAD_W-1:0] enq_payload;
    logic [FU_W-1:0]      enq_fu;
    logic                 enq_halt;
    logic [NUM_FU-1:0]    fu_stall;
    logic                 issue_valid;
    logic [PAYLOAD_W-1:0] issue_payload;
    logic [FU_W-1:0]      issue_fu;
    logic                 issue_halt;
    logic [CNT_W-1:0]     count;
    logic                 empty;
    logic                 full;
    logic                 halted;

    int n_pass = 0;
    int n_tot  = 0;

    ooo_decode_issue_queue #(
        .DEPTH(DEPTH), .PAYLOAD_W(PAYLOAD_W), .NUM_FU(NUM_FU)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_flush(flush),
        .i_enq_valid(enq_valid), .o_enq_ready(enq_ready),
        .i_enq_payload(enq_payload), .i_enq_fu(enq_fu), .i_enq_halt(enq_halt),
        .i_fu_stall(fu_stall),
        .o_issue_valid(issue_valid), .o_issue_payload(issue_payload),
        .o_issue_fu(issue_fu), .o_issue_halt(issue_halt),
        .o_count(count), .o_empty(empty), .o_full(full), .o_halted(halted)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        fl, ev;
        logic [15:0] pl;
        logic [2:0]  fu;
        logic        ht;
        logic [4:0]  st;
        logic        iv;
        logic [15:0] ipl;
        logic [2:0]  ifu;
        logic        iht;
        logic [2:0]  cnt;
        logic        emp, ful, hlt, rdy;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(logic fl, logic ev, logic [15:0] pl, logic [2:0] fu,
                                logic ht, logic [4:0] st, logic iv, logic [15:0] ipl,
                                logic [2:0] ifu, logic iht, logic [2:0] cnt,
                                logic emp, logic ful, logic hlt, logic rdy);
        vec_t v;
        v.fl = fl; v.ev = ev; v.pl = pl; v.fu = fu; v.ht = ht; v.st = st;
        v.iv = iv; v.ipl = ipl; v.ifu = ifu; v.iht = iht; v.cnt = cnt;
        v.emp = emp; v.ful = ful; v.hlt = hlt; v.rdy = rdy;
        return v;
    endfunction

    // Spread a 16-bit tag over the whole payload so every bit lane is exercised.
    function automatic logic [PAYLOAD_W-1:0] mkpl(logic [15:0] t);
        return {(PAYLOAD_W / 16){t}};
    endfunction

    task automatic chk(string nm, logic [PAYLOAD_W-1:0] act, logic [PAYLOAD_W-1:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic drive(logic fl, logic ev, logic [15:0] pl, logic [2:0] fu,
                         logic ht, logic [4:0] st);
        flush = fl; enq_valid = ev; enq_payload = mkpl(pl);
        enq_fu = FU_W'(fu); enq_halt = ht; fu_stall = st;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [15:0] model[$];
    logic [15:0] tag;

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // fields: fl ev pl fu ht st | iv ipl ifu iht cnt emp ful hlt rdy
        vt.push_back(mk(0,0,16'h00,0,0,5'h00, 0,16'h00,0,0,0,1,0,0,1));
        vt.push_back(mk(0,1,16'hA5,0,0,5'h00, 0,16'h00,0,0,0,1,0,0,1));
        vt.push_back(mk(0,0,16'h00,0,0,5'h00, 1,16'hA5,0,0,1,0,0,0,1));
        vt.push_back(mk(0,0,16'h00,0,0,5'h00, 0,16'h00,0,0,0,1,0,0,1));
        vt.push_back(mk(0,1,16'h11,0,0,5'h1F, 0,16'h00,0,0,0,1,0,0,1));
        vt.push_back(mk(0,1,16'h22,1,0,5'h1F, 0,16'h00,0,0,1,0,0,0,1));
        vt.push_back(mk(0,1,16'h33,2,0,5'h1F, 0,16'h00,0,0,2,0,0,0,1));
        vt.push_back(mk(0,1,16'h44,3,0,5'h1F, 0,16'h00,0,0,3,0,0,0,1));
        vt.push_back(mk(0,1,16'h55,4,0,5'h1F, 0,16'h00,0,0,4,0,1,0,0));
        vt.push_back(mk(0,1,16'h55,4,0,5'h00, 1,16'h11,0,0,4,0,1,0,0));
        vt.push_back(mk(0,0,16'h00,0,0,5'h00, 1,16'h22,1,0,3,0,0,0,1));
        vt.push_back(mk(0,0,16'h00,0,0,5'h00, 1,16'h33,2,0,2,0,0,0,1));
        vt.push_back(mk(0,0,16'h00,0,0,5'h00, 1,16'h44,3,0,1,0,0,0,1));
        vt.push_back(mk(0,0,16'h00,0,0,5'h00, 0,16'h00,0,0,0,1,0,0,1));
        vt.push_back(mk(0,1,16'h66,2,0,5'h04, 0,16'h00,0,0,0,1,0,0,1));
        vt.push_back(mk(0,1,16'h77,0,0,5'h04, 0,16'h00,0,0,1,0,0,0,1));
        vt.push_back(mk(0,0,16'h00,0,0,5'h04, 0,16'h00,0,0,2,0,0,0,1));
        vt.push_back(mk(0,0,16'h00,0,0,5'h00, 1,16'h66,2,0,2,0,0,0,1));
        vt.push_back(mk(0,0,16'h00,0,0,5'h04, 1,16'h77,0,0,1,0,0,0,1));
        vt.push_back(mk(0,0,16'h00,0,0,5'h00, 0,16'h00,0,0,0,1,0,0,1));
        vt.push_back(mk(0,1,16'h81,1,0,5'h1F, 0,16'h00,0,0,0,1,0,0,1));
        vt.push_back(mk(0,1,16'h82,1,0,5'h1F, 0,16'h00,0,0,1,0,0,0,1));
        vt.push_back(mk(0,1,16'h83,1,0,5'h1F, 0,16'h00,0,0,2,0,0,0,1));
        vt.push_back(mk(1,1,16'h84,0,0,5'h00, 0,16'h00,0,0,3,0,0,0,1));
        vt.push_back(mk(0,0,16'h00,0,0,5'h00, 0,16'h00,0,0,0,1,0,0,1));
        vt.push_back(mk(0,1,16'h91,0,0,5'h1F, 0,16'h00,0,0,0,1,0,0,1));
        vt.push_back(mk(0,1,16'h92,1,0,5'h1F, 0,16'h00,0,0,1,0,0,0,1));
        vt.push_back(mk(0,1,16'h93,4,1,5'h1F, 0,16'h00,0,0,2,0,0,0,1));
        vt.push_back(mk(0,1,16'h94,0,0,5'h1F, 0,16'h00,0,0,3,0,0,1,0));
        vt.push_back(mk(0,1,16'h94,0,0,5'h00, 1,16'h91,0,0,3,0,0,1,0));
        vt.push_back(mk(0,0,16'h00,0,0,5'h00, 1,16'h92,1,0,2,0,0,1,0));
        vt.push_back(mk(0,0,16'h00,0,0,5'h00, 1,16'h93,4,1,1,0,0,1,0));
        vt.push_back(mk(0,0,16'h00,0,0,5'h00, 0,16'h00,0,0,0,1,0,1,0));
        vt.push_back(mk(1,0,16'h00,0,0,5'h00, 0,16'h00,0,0,0,1,0,1,0));
        vt.push_back(mk(0,0,16'h00,0,0,5'h00, 0,16'h00,0,0,0,1,0,0,1));

        foreach (vt[i]) begin
            drive(vt[i].fl, vt[i].ev, vt[i].pl, vt[i].fu, vt[i].ht, vt[i].st);
            #2;
            chk($sformatf("v%0d.issue_valid", i), PAYLOAD_W'(issue_valid), PAYLOAD_W'(vt[i].iv));
            chk($sformatf("v%0d.issue_payload", i), issue_payload,
                vt[i].iv ? mkpl(vt[i].ipl) : '0);
            chk($sformatf("v%0d.issue_fu", i), PAYLOAD_W'(issue_fu), PAYLOAD_W'(vt[i].ifu));
            chk($sformatf("v%0d.issue_halt", i), PAYLOAD_W'(issue_halt), PAYLOAD_W'(vt[i].iht));
            chk($sformatf("v%0d.count", i), PAYLOAD_W'(count), PAYLOAD_W'(vt[i].cnt));
            chk($sformatf("v%0d.empty", i), PAYLOAD_W'(empty), PAYLOAD_W'(vt[i].emp));
            chk($sformatf("v%0d.full", i), PAYLOAD_W'(full), PAYLOAD_W'(vt[i].ful));
            chk($sformatf("v%0d.halted", i), PAYLOAD_W'(halted), PAYLOAD_W'(vt[i].hlt));
            chk($sformatf("v%0d.enq_ready", i), PAYLOAD_W'(enq_ready), PAYLOAD_W'(vt[i].rdy));
            step();
        end

        // Steady state at count=2: enqueue and issue together for 10 cycles.
        model.delete();
        drive(0, 1, 16'hC1, 0, 0, 5'h1F); model.push_back(16'hC1); step();
        drive(0, 1, 16'hC2, 1, 0, 5'h1F); model.push_back(16'hC2); step();
        for (int k = 0; k < 10; k++) begin
            tag = 16'h0100 + 16'(k);
            drive(0, 1, tag, 3'(k % NUM_FU), 0, 5'h00);
            #2;
            chk($sformatf("wrap%0d.count", k), PAYLOAD_W'(count), PAYLOAD_W'(2));
            chk($sformatf("wrap%0d.issue_valid", k), PAYLOAD_W'(issue_valid), PAYLOAD_W'(1));
            chk($sformatf("wrap%0d.issue_payload", k), issue_payload, mkpl(model[0]));
            step();
            void'(model.pop_front());
            model.push_back(tag);
        end
        for (int k = 0; k < 2; k++) begin
            drive(0, 0, 0, 0, 0, 5'h00);
            #2;
            chk($sformatf("drain%0d.issue_payload", k), issue_payload, mkpl(model[0]));
            step();
            void'(model.pop_front());
        end
        chk("drain.empty", PAYLOAD_W'(empty), PAYLOAD_W'(1));

        // Reset mid-operation abandons queued packets.
        drive(0, 1, 16'hD1, 0, 0, 5'h1F); step();
        drive(0, 1, 16'hD2, 0, 0, 5'h1F); step();
        drive(0, 0, 0, 0, 0, 5'h1F);
        #2;
        chk("prerst.count", PAYLOAD_W'(count), PAYLOAD_W'(2));
        rst = 1'b1;
        fu_stall = 5'h00;
        #1;
        chk("rst.count", PAYLOAD_W'(count), PAYLOAD_W'(0));
        chk("rst.empty", PAYLOAD_W'(empty), PAYLOAD_W'(1));
        chk("rst.issue_valid", PAYLOAD_W'(issue_valid), PAYLOAD_W'(0));
        chk("rst.enq_ready", PAYLOAD_W'(enq_ready), PAYLOAD_W'(1));
        step();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #2;
            chk($sformatf("postrst%0d.issue_valid", k), PAYLOAD_W'(issue_valid), PAYLOAD_W'(0));
            step();
        end
        drive(0, 1, 16'hE1, 2, 0, 5'h00); step();
        drive(0, 0, 0, 0, 0, 5'h00);
        #2;
        chk("postrst.issue_payload", issue_payload, mkpl(16'hE1));
        chk("postrst.issue_fu", PAYLOAD_W'(issue_fu), PAYLOAD_W'(2));
        step();

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
